// File: rtl/jacobian_det.sv
// jacobian_det: determinant of the 2x2 arm Jacobian, flagging near-singular poses.
// jd_fp_unit is a fixed-latency double multiply/add unit (truncating, denormals flushed).

module jd_fp_unit #(
  parameter int LAT    = 3,
  parameter bit IS_ADD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        data_ready,
  output logic [63:0] result
);
  function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y);
    logic [105:0]       m;
    logic signed [12:0] e;
    logic [51:0]        f;
    logic               s;
    s = x[63] ^ y[63];
    m = 106'({1'b1, x[51:0]}) * 106'({1'b1, y[51:0]});
    e = $signed({2'b00, x[62:52]}) + $signed({2'b00, y[62:52]}) - 13'sd1023;
    if (m[105]) begin
      f = m[104:53];
      e = e + 13'sd1;
    end else begin
      f = m[103:52];
    end
    if (x[62:52] == 11'd0 || y[62:52] == 11'd0) return {s, 63'd0};
    else if (x[62:52] == 11'h7FF || y[62:52] == 11'h7FF) return {s, 11'h7FF, 52'd0};
    else if (e <= 13'sd0) return {s, 63'd0};
    else if (e >= 13'sd2047) return {s, 11'h7FF, 52'd0};
    else return {s, e[10:0], f};
  endfunction

  function automatic logic [63:0] fadd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0]        big, sml;
    logic [53:0]        mb, ms, sum, norm;
    logic [10:0]        d;
    logic [5:0]         pos, sh;
    logic signed [12:0] e;
    if (x[62:0] >= y[62:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    d   = big[62:52] - sml[62:52];
    mb  = {2'b01, big[51:0]};
    ms  = (sml[62:52] == 11'd0 || d > 11'd53) ? 54'd0 : ({2'b01, sml[51:0]} >> d);
    sum = (big[63] == sml[63]) ? (mb + ms) : (mb - ms);
    pos = 6'd0;
    for (int i = 0; i < 53; i++) begin
      if (sum[i]) pos = 6'(i);
    end
    sh   = 6'd52 - pos;
    norm = sum << sh;
    e    = $signed({2'b00, big[62:52]}) - $signed({7'd0, sh});
    // Only -0 + -0 keeps the negative sign; exact cancellation gives +0.
    if (big[62:52] == 11'd0) return {x[63] & y[63], 63'd0};
    else if (big[62:52] == 11'h7FF) return big;
    else if (sum == 54'd0) return 64'd0;
    else if (sum[53]) return (big[62:52] == 11'h7FE) ? {big[63], 11'h7FF, 52'd0}
                                                     : {big[63], big[62:52] + 11'd1, sum[52:1]};
    else if (e <= 13'sd0) return {big[63], 63'd0};
    else return {big[63], e[10:0], norm[51:0]};
  endfunction

  logic [7:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (in_ready) begin
      a_d   = op_a;
      b_d   = op_b;
      cnt_d = 8'(LAT - 1);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    if ((in_ready && LAT == 1) || (!in_ready && cnt_q == 8'd1)) begin
      rdy_d = 1'b1;
      res_d = IS_ADD ? fadd(a_d, b_d) : fmul(a_d, b_d);
    end else begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      rdy_q <= 1'b0;
      a_q   <= 64'd0;
      b_q   <= 64'd0;
      res_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  assign data_ready = rdy_q;
  assign result     = res_q;
endmodule

module jacobian_det #(
  parameter logic [10:0] SING_EXP = 11'd1003,
  parameter int          TIMEOUT  = 64,
  parameter int          TW       = 7,
  parameter int          MUL_LAT  = 3,
  parameter int          ADD_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] dx_dth1,
  input  logic [63:0] dx_dth2,
  input  logic [63:0] dy_dth1,
  input  logic [63:0] dy_dth2,
  output logic [63:0] det,
  output logic        det_valid,
  output logic        singular,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_MULT = 2'd2;
  localparam logic [1:0] S_SUB  = 2'd3;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          in_valid_q, in_valid_d, armed_q, armed_d;
  logic [63:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, det_q, det_d;
  logic          det_valid_q, det_valid_d, singular_q, singular_d, busy_q, busy_d;
  logic          overrun_q, overrun_d, timeout_err_q, timeout_err_d;
  logic          rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unit_rst_s, start_s, mul_go_s, add_go_s;
  logic          mul0_rdy_s, mul1_rdy_s, add_rdy_s;
  logic [63:0]   p0_s, p1_s, add_res_s;

  assign unit_rst_s = ~reset;
  // armed_q blocks a start from an in_valid level that was already high out of reset.
  assign start_s    = in_valid & ~in_valid_q & armed_q;
  assign mul_go_s   = (state_q == S_CAPT);

  jd_fp_unit #(.LAT(MUL_LAT), .IS_ADD(1'b0)) u_mul0 (
    .clk(clk), .rst(unit_rst_s), .in_ready(mul_go_s), .op_a(a_q), .op_b(d_q),
    .data_ready(mul0_rdy_s), .result(p0_s));
  jd_fp_unit #(.LAT(MUL_LAT), .IS_ADD(1'b0)) u_mul1 (
    .clk(clk), .rst(unit_rst_s), .in_ready(mul_go_s), .op_a(b_q), .op_b(c_q),
    .data_ready(mul1_rdy_s), .result(p1_s));
  jd_fp_unit #(.LAT(ADD_LAT), .IS_ADD(1'b1)) u_add (
    .clk(clk), .rst(unit_rst_s), .in_ready(add_go_s), .op_a(p0_s),
    .op_b({~p1_s[63], p1_s[62:0]}), .data_ready(add_rdy_s), .result(add_res_s));

  always_comb begin
    state_d       = state_q;
    in_valid_d    = in_valid;
    armed_d       = armed_q | ~in_valid;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    det_d         = det_q;
    det_valid_d   = det_valid_q;
    singular_d    = singular_q;
    overrun_d     = (start_s && state_q != S_IDLE) ? 1'b1 : overrun_q;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;
    rdy0_d        = rdy0_q;
    rdy1_d        = rdy1_q;
    add_go_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          a_d           = dx_dth1;
          b_d           = dx_dth2;
          c_d           = dy_dth1;
          d_d           = dy_dth2;
          det_valid_d   = 1'b0;
          singular_d    = 1'b0;
          overrun_d     = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = S_CAPT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPT: begin
        timer_d = {TW{1'b0}};
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        state_d = S_MULT;
      end
      S_MULT: begin
        rdy0_d = rdy0_q | mul0_rdy_s;
        rdy1_d = rdy1_q | mul1_rdy_s;
        if (rdy0_d && rdy1_d) begin
          add_go_s = 1'b1;
          timer_d  = {TW{1'b0}};
          state_d  = S_SUB;
        end else if (timer_q == TMAX) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SUB: begin
        if (add_rdy_s) begin
          det_d       = add_res_s;
          singular_d  = (add_res_s[62:52] < SING_EXP) | (add_res_s[62:52] == 11'h7FF);
          det_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q == TMAX) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      in_valid_q    <= 1'b0;
      armed_q       <= 1'b0;
      a_q           <= 64'd0;
      b_q           <= 64'd0;
      c_q           <= 64'd0;
      d_q           <= 64'd0;
      det_q         <= 64'd0;
      det_valid_q   <= 1'b0;
      singular_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= {TW{1'b0}};
      rdy0_q        <= 1'b0;
      rdy1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_valid_q    <= in_valid_d;
      armed_q       <= armed_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      det_q         <= det_d;
      det_valid_q   <= det_valid_d;
      singular_q    <= singular_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
      rdy0_q        <= rdy0_d;
      rdy1_q        <= rdy1_d;
    end
  end

  assign det         = det_q;
  assign det_valid   = det_valid_q;
  assign singular    = singular_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
endmodule
